// File: rtl/conv3x3_relu_engine.sv
// 3x3 multi-kernel convolution engine: zero-padded taps fetched one per cycle, all kernels
// accumulate in parallel, then bias, round-half-up, ReLU and saturation before per-kernel writes.
module conv3x3_relu_engine #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 20,
    parameter int FRAC  = 16,
    parameter int NK    = 2,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    output logic                 busy,
    output logic [AW-1:0]        iaddr,
    input  logic signed [DW-1:0] idata,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic signed [DW-1:0] cfg_data,
    output logic                 cwr,
    output logic [AW-1:0]        caddr_wr,
    output logic signed [DW-1:0] cdata_wr,
    output logic [2:0]           csel,
    output logic                 done
);
    localparam int ACC_W = 2*DW + 4;
    localparam int SUM_W = 2*DW + 6;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [1:0]    WR_LAST  = 2'(NK - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DW-1)) - 64'sd1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic signed [DW-1:0] round_relu_sat(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [DW-1:0]    bias
    );
        logic signed [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC) + (SUM_W'(1) <<< (FRAC-1));
        sum = sum >>> FRAC;
        if (sum < 0)
            return '0;
        if (sum > SAT_MAX)
            return SAT_MAX[DW-1:0];
        return sum[DW-1:0];
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    t_q, t_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [AW-1:0] ahold_q;
    logic          tapv_q;
    logic [3:0]    tidx_q;

    logic signed [DW-1:0]    w_q   [NK][9];
    logic signed [DW-1:0]    b_q   [NK];
    logic signed [ACC_W-1:0] acc_q [NK];
    logic signed [DW-1:0]    res_q [NK];
    logic signed [2*DW-1:0]  prod  [NK];

    logic [1:0]           tr, tc;
    logic                 tap_in;
    logic                 fetch_issue;
    int                   tap_off;
    logic [AW-1:0]        tap_addr;
    logic signed [DW-1:0] wdata;

    // Tap t maps to neighbourhood row tr and column tc (0..2 = offset -1..+1).
    always_comb begin
        tr = 2'd0;
        tc = 2'd0;
        case (t_q)
            4'd1: tc = 2'd1;
            4'd2: tc = 2'd2;
            4'd3: tr = 2'd1;
            4'd4: begin tr = 2'd1; tc = 2'd1; end
            4'd5: begin tr = 2'd1; tc = 2'd2; end
            4'd6: tr = 2'd2;
            4'd7: begin tr = 2'd2; tc = 2'd1; end
            4'd8: begin tr = 2'd2; tc = 2'd2; end
            default: ;
        endcase
        tap_in = !((tr == 2'd0) && (row_q == '0)) && !((tr == 2'd2) && (row_q == ROW_LAST)) &&
                 !((tc == 2'd0) && (col_q == '0)) && !((tc == 2'd2) && (col_q == COL_LAST));
        tap_off     = (int'(tr) - 1) * IMG_W + int'(tc) - 1;
        tap_addr    = pix_q + AW'(tap_off);
        fetch_issue = (state_q == S_FETCH) && (t_q <= 4'd8) && tap_in;
    end

    // Out-of-image taps leave the address bus parked on the last issued address.
    assign iaddr = fetch_issue ? tap_addr : ahold_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        wcnt_d  = wcnt_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_FETCH;
                    t_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    pix_d   = '0;
                end
            end
            S_FETCH: begin
                if (t_q == 4'd9)
                    state_d = S_ROUND;
                else
                    t_d = t_q + 4'd1;
            end
            S_ROUND: begin
                state_d = S_WRITE;
                wcnt_d  = '0;
            end
            S_WRITE: begin
                if (wcnt_q != WR_LAST) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    t_d     = '0;
                    pix_d   = pix_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            wcnt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            ahold_q <= '0;
            tapv_q  <= 1'b0;
            tidx_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            wcnt_q  <= wcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            ahold_q <= iaddr;
            tapv_q  <= fetch_issue;
            tidx_q  <= t_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NK; k++) begin
                b_q[k] <= '0;
                for (int i = 0; i < 9; i++)
                    w_q[k][i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            for (int k = 0; k < NK; k++) begin
                for (int i = 0; i < 9; i++)
                    if (cfg_addr == 6'(k*10 + i))
                        w_q[k][i] <= cfg_data;
                if (cfg_addr == 6'(k*10 + 9))
                    b_q[k] <= cfg_data;
            end
        end
    end

    // Sample returned the cycle after its address; tidx_q/tapv_q describe that tap.
    always_comb begin
        for (int k = 0; k < NK; k++)
            prod[k] = idata * w_q[k][tidx_q];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (state_q == S_FETCH) begin
                if (t_q == 4'd0)
                    acc_q[k] <= '0;
                else if (tapv_q)
                    acc_q[k] <= acc_q[k] + ACC_W'(prod[k]);
            end
            if (state_q == S_ROUND)
                res_q[k] <= round_relu_sat(acc_q[k], b_q[k]);
        end
    end

    always_comb begin
        wdata = '0;
        for (int k = 0; k < NK; k++)
            if (wcnt_q == 2'(k))
                wdata = res_q[k];
    end

    assign busy     = (state_q == S_FETCH) || (state_q == S_ROUND) || (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign cwr      = (state_q == S_WRITE);
    assign csel     = cwr ? (3'(wcnt_q) + 3'd1) : 3'd0;
    assign caddr_wr = cwr ? pix_q : '0;
    assign cdata_wr = cwr ? wdata : '0;

endmodule

// File: tb/tb_conv3x3_relu_engine.sv
// Self-checking bench for conv3x3_relu_engine on a 5x4 image with three kernels, checked
// against an arithmetic reference of the padded 3x3 convolution with bias, rounding, ReLU, saturation.
module tb_conv3x3_relu_engine;
    localparam int W      = 5;
    localparam int H      = 4;
    localparam int DW     = 20;
    localparam int FRAC   = 16;
    localparam int NK     = 3;
    localparam int AW     = $clog2(W*H);
    localparam int NPIX   = W*H;
    localparam int PIXCYC = 11 + NK;
    localparam longint SATV = (longint'(1) <<< (DW-1)) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 ready = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [5:0]           cfg_addr = '0;
    logic signed [DW-1:0] cfg_data = '0;
    logic signed [DW-1:0] idata = '0;
    logic                 busy, cwr, done;
    logic [AW-1:0]        iaddr, caddr_wr;
    logic signed [DW-1:0] cdata_wr;
    logic [2:0]           csel;

    typedef struct packed {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int  img [NPIX];
    int  mw  [NK][9];
    int  mb  [NK];
    wr_t wq  [$];
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, prot_err = 0;

    conv3x3_relu_engine #(.IMG_W(W), .IMG_H(H), .DW(DW), .FRAC(FRAC), .NK(NK)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) idata <= (int'(iaddr) < NPIX) ? DW'(img[iaddr]) : '0;

    always @(negedge clk) begin
        wr_t w;
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cwr) begin
            w.sel = csel; w.addr = caddr_wr; w.data = cdata_wr;
            wq.push_back(w);
        end
        if ((cwr && !busy) || (cwr != (csel != 3'd0)) || (done && busy)) prot_err++;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_px(int k, int r, int c);
        longint acc = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W)
                    acc += longint'(img[(r+dr)*W + c+dc]) * longint'(mw[k][(dr+1)*3 + dc+1]);
        acc = (acc + (longint'(mb[k]) <<< FRAC) + (longint'(1) <<< (FRAC-1))) >>> FRAC;
        if (acc < 0) return 0;
        if (acc > SATV) return SATV;
        return acc;
    endfunction

    function automatic longint wr_data(int p, int k);
        if (p*NK + k < wq.size()) return longint'(wq[p*NK + k].data);
        return -1;
    endfunction

    task automatic cfg_wr(input int k, input int idx, input int val, input bit upd);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'(k*10 + idx); cfg_data = DW'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        if (upd) begin
            if (idx == 9) mb[k] = val;
            else mw[k][idx] = val;
        end
    endtask

    task automatic program_all();
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 10; i++)
                cfg_wr(k, i, (i == 9) ? mb[k] : mw[k][i], 1'b0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NK; k++) begin
            mb[k] = 0;
            for (int i = 0; i < 9; i++) mw[k][i] = 0;
        end
    endtask

    task automatic run_frame(input string name, input bit lock_wr);
        int rcyc;
        wq.delete(); busy_cnt = 0; done_cnt = 0; prot_err = 0;
        @(negedge clk);
        check_eq({name, "_busy_idle"}, longint'(busy), 0);
        ready = 1'b1; rcyc = cyc;
        @(negedge clk);
        ready = 1'b0;
        check_eq({name, "_busy_rise"}, longint'(busy), 1);
        if (lock_wr) begin
            repeat (20) @(negedge clk);
            cfg_wr(0, 9, 'h3000, 1'b0);
        end
        for (int i = 0; i < NPIX*PIXCYC + 20 && done_cnt == 0; i++) @(posedge clk);
        check_eq({name, "_done_seen"}, longint'(done_cnt != 0), 1);
        repeat (5) @(negedge clk);
        check_eq({name, "_latency"}, longint'(done_cyc - rcyc), 1 + NPIX*PIXCYC);
        check_eq({name, "_busy_cycles"}, busy_cnt, NPIX*PIXCYC);
        check_eq({name, "_done_pulses"}, done_cnt, 1);
        check_eq({name, "_nwrites"}, wq.size(), NPIX*NK);
        check_eq({name, "_protocol"}, prot_err, 0);
        for (int p = 0; p < NPIX && p*NK + NK <= wq.size(); p++)
            for (int k = 0; k < NK; k++) begin
                check_eq($sformatf("%s_p%0d_k%0d_sel", name, p, k), wq[p*NK+k].sel, k + 1);
                check_eq($sformatf("%s_p%0d_k%0d_addr", name, p, k), wq[p*NK+k].addr, p);
                check_eq($sformatf("%s_p%0d_k%0d_data", name, p, k), wr_data(p, k), ref_px(k, p / W, p % W));
            end
    endtask

    task automatic randomize_frame(input bit weights);
        for (int p = 0; p < NPIX; p++) img[p] = int'($urandom_range(0, 262143)) - 131072;
        if (weights) begin
            for (int k = 0; k < NK; k++) begin
                mb[k] = int'($urandom_range(0, 262143)) - 131072;
                for (int i = 0; i < 9; i++) mw[k][i] = int'($urandom_range(0, 131071)) - 65536;
            end
        end
    endtask

    initial begin
        int nrst;
        clear_model();
        for (int p = 0; p < NPIX; p++) img[p] = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_iaddr", iaddr, 0);
        check_eq("rst_cwr", cwr, 0);
        check_eq("rst_caddr", caddr_wr, 0);
        check_eq("rst_cdata", longint'(cdata_wr), 0);
        check_eq("rst_csel", csel, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b1;

        for (int p = 0; p < NPIX; p++) img[p] = p << 8;
        mw[0][4] = 'h10000; mb[1] = 'h01000; mw[2][0] = 'h10000;
        program_all();
        run_frame("ident", 1'b0);
        check_eq("ident_k0_a7", wr_data(7, 0), 7 << 8);
        check_eq("ident_k1_a7", wr_data(7, 1), 'h1000);
        check_eq("ident_k2_a7", wr_data(7, 2), 1 << 8);

        for (int p = 0; p < NPIX; p++) img[p] = 'h10000;
        for (int i = 0; i < 9; i++) mw[0][i] = 'h10000;
        program_all();
        run_frame("sat", 1'b0);
        check_eq("sat_corner0", wr_data(0, 0), 'h40000);
        check_eq("sat_edge1", wr_data(1, 0), 'h60000);
        check_eq("sat_edge5", wr_data(5, 0), 'h60000);
        check_eq("sat_interior6", wr_data(6, 0), 'h7FFFF);
        check_eq("sat_corner19", wr_data(19, 0), 'h40000);

        clear_model();
        for (int p = 0; p < NPIX; p++) img[p] = (p % 2 == 0) ? 1 : 'h8000;
        mw[0][4] = 'h8000; mw[1][4] = 'h10000; mb[1] = -65536;
        program_all();
        run_frame("rnd", 1'b0);
        check_eq("rnd_halfup", wr_data(0, 0), 1);
        check_eq("rnd_quarter", wr_data(1, 0), 'h4000);
        check_eq("relu_neg_bias", wr_data(1, 1), 0);

        randomize_frame(1'b1);
        program_all();
        run_frame("rand1", 1'b0);
        randomize_frame(1'b1);
        program_all();
        run_frame("rand2", 1'b0);

        randomize_frame(1'b0);
        for (int i = 0; i < 9; i++) mw[0][i] = 0;
        mw[0][4] = 'h10000; mb[0] = 0;
        program_all();
        run_frame("lock", 1'b1);
        cfg_wr(0, 9, 'h3000, 1'b1);
        cfg_wr(3, 0, 'h12345, 1'b0);
        run_frame("reload", 1'b0);

        wq.delete();
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        for (int i = 0; i < 3000 && wq.size() < 5*NK + 1; i++) @(negedge clk);
        #1;
        check_eq("mid_cwr_before", cwr, 1);
        nrst = wq.size();
        reset = 1'b0;
        #1;
        check_eq("mid_cwr", cwr, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_csel", csel, 0);
        check_eq("mid_caddr", caddr_wr, 0);
        check_eq("mid_cdata", longint'(cdata_wr), 0);
        check_eq("mid_iaddr", iaddr, 0);
        check_eq("mid_done", done, 0);
        repeat (3) @(negedge clk);
        check_eq("mid_no_writes", wq.size(), nrst);
        reset = 1'b1;
        clear_model();
        run_frame("post_rst", 1'b0);

        randomize_frame(1'b1);
        program_all();
        run_frame("rand3", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
